// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the register-file arbiter.
// Contents: row/width constants, FSM state encodings, op codes,
// port index type, latched command payload and a range-check helper.
package memory_arbiter_pkg;

  localparam int unsigned NUM_ROWS = 10;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 16;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef logic port_t;

  // Command captured on the handshake edge; oor marks an out-of-range row.
  typedef struct packed {
    logic              op;
    port_t             port;
    logic              oor;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Any address at or above NUM_ROWS would alias through the 4-bit row decode.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return addr >= ADDR_W'(NUM_ROWS);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick, purely combinational.
// Ports: valid[1:0] request pending per port, last_grant port that won the
// most recent accept, grant_c[1:0] one-hot winner (zero when nothing valid).
module rr_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  port_t      last_grant,
  output logic [1:0] grant_c
);

  // A lone valid wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
      grant_c = (last_grant == 1'b1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the cell-state /
// ccr register file. Turns valid/ready requests into one-cycle active-low
// strobes and returns read data with a one-cycle rvalid pulse.
// Ports: clock, reset_sn (sync active-low); per requester N in {0,1}:
// reqN_valid/write/address/wdata in, reqN_ready (combinational),
// reqN_rvalid/rdata/err out; memory_enable_n/write_n/read_n/address/
// data_in out to the register file, memory_data_out in (registered read).
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_sn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              memory_enable_n,
  output logic              memory_write_n,
  output logic              memory_read_n,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data_in,
  input  logic [DATA_W-1:0] memory_data_out
);

  logic [1:0]        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  port_t             last_grant_q, last_grant_d;
  logic [1:0]        grant_c;
  logic              enable_n_d, write_n_d, read_n_d;
  logic [1:0]        rvalid_d, err_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  port_t             sel_c;

  rr_arbiter_2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  assign req0_ready = (state_q == IDLE) & grant_c[0];
  assign req1_ready = (state_q == IDLE) & grant_c[1];
  assign sel_c      = grant_c[1];

  // Address and write data come straight from the latched command flops.
  assign memory_address = cmd_q.addr;
  assign memory_data_in = cmd_q.wdata;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_grant_d = last_grant_q;
    enable_n_d   = 1'b1;
    write_n_d    = 1'b1;
    read_n_d     = 1'b1;
    rvalid_d     = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = req0_rdata;
    rdata1_d     = req1_rdata;
    case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          cmd_d.port   = sel_c;
          cmd_d.op     = sel_c ? req1_write   : req0_write;
          cmd_d.addr   = sel_c ? req1_address : req0_address;
          cmd_d.wdata  = sel_c ? req1_wdata   : req0_wdata;
          cmd_d.oor    = addr_out_of_range(cmd_d.addr);
          last_grant_d = sel_c;
          state_d      = CMD;
          // Strobes are launched here so they are low for the CMD cycle only.
          if (!cmd_d.oor) begin
            enable_n_d = 1'b0;
            write_n_d  = (cmd_d.op != OP_WRITE);
            read_n_d   = (cmd_d.op != OP_READ);
          end
        end
      end
      CMD: begin
        if (cmd_q.op == OP_WRITE) begin
          state_d = IDLE;
          err_d[cmd_q.port] = cmd_q.oor;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        rvalid_d[cmd_q.port] = 1'b1;
        err_d[cmd_q.port]    = cmd_q.oor;
        if (cmd_q.port == 1'b0) begin
          rdata0_d = cmd_q.oor ? '0 : memory_data_out;
        end else begin
          rdata1_d = cmd_q.oor ? '0 : memory_data_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_sn) begin
      state_q         <= IDLE;
      cmd_q           <= '0;
      last_grant_q    <= 1'b1;
      memory_enable_n <= 1'b1;
      memory_write_n  <= 1'b1;
      memory_read_n   <= 1'b1;
      req0_rvalid     <= 1'b0;
      req1_rvalid     <= 1'b0;
      req0_err        <= 1'b0;
      req1_err        <= 1'b0;
      req0_rdata      <= '0;
      req1_rdata      <= '0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      last_grant_q    <= last_grant_d;
      memory_enable_n <= enable_n_d;
      memory_write_n  <= write_n_d;
      memory_read_n   <= read_n_d;
      req0_rvalid     <= rvalid_d[0];
      req1_rvalid     <= rvalid_d[1];
      req0_err        <= err_d[0];
      req1_err        <= err_d[1];
      req0_rdata      <= rdata0_d;
      req1_rdata      <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 16-entry register
// file (4-bit row decode, registered read) attached to the memory port.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_sn;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0]  req0_address, req1_address;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_err, req1_err;
  logic [15:0] req0_rdata, req1_rdata;
  logic        memory_enable_n, memory_write_n, memory_read_n;
  logic [7:0]  memory_address;
  logic [15:0] memory_data_in, memory_data_out;

  logic [15:0] rf [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  memory_arbiter dut (
    .clock(clock), .reset_sn(reset_sn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .memory_enable_n(memory_enable_n), .memory_write_n(memory_write_n),
    .memory_read_n(memory_read_n), .memory_address(memory_address),
    .memory_data_in(memory_data_in), .memory_data_out(memory_data_out)
  );

  // Register file model: aliasing 4-bit decode, registered read data.
  always @(posedge clock) begin
    if (!memory_enable_n && !memory_write_n) rf[memory_address[3:0]] <= memory_data_in;
    if (!memory_enable_n && !memory_read_n) memory_data_out <= rf[memory_address[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    memory_data_out = 16'h0;
    reset_sn = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_address = 8'h0; req0_wdata = 16'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_address = 8'h0; req1_wdata = 16'h0;
    tick();
    tick();
    check("rst_en_n", 32'(memory_enable_n), 32'd1);
    check("rst_wr_n", 32'(memory_write_n), 32'd1);
    check("rst_rd_n", 32'(memory_read_n), 32'd1);
    check("rst_addr", 32'(memory_address), 32'd0);
    check("rst_din", 32'(memory_data_in), 32'd0);
    check("rst_rvalid", 32'({req1_rvalid, req0_rvalid, req1_err, req0_err}), 32'd0);
    check("rst_rdata", 32'({req1_rdata, req0_rdata}), 32'd0);
    reset_sn = 1'b1;
    tick();

    // req0 write row 2
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 8'd2; req0_wdata = 16'hBEEF;
    #1;
    check("w_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("w_en_n", 32'(memory_enable_n), 32'd0);
    check("w_wr_n", 32'(memory_write_n), 32'd0);
    check("w_rd_n", 32'(memory_read_n), 32'd1);
    check("w_addr", 32'(memory_address), 32'd2);
    check("w_din", 32'(memory_data_in), 32'hBEEF);
    check("w_ready_cmd", 32'(req0_ready), 32'd0);
    tick();
    check("w_strobe_end", 32'({memory_enable_n, memory_write_n}), 32'd3);
    check("w_row2", 32'(rf[2]), 32'hBEEF);

    // req1 read row 2
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 8'd2;
    #1;
    check("r_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("r_rd_n", 32'({memory_enable_n, memory_read_n, memory_write_n}), 32'd1);
    tick();
    check("r_resp_rvalid", 32'(req1_rvalid), 32'd0);
    tick();
    check("r_rvalid1", 32'(req1_rvalid), 32'd1);
    check("r_rdata1", 32'(req1_rdata), 32'hBEEF);
    check("r_rvalid0", 32'(req0_rvalid), 32'd0);
    tick();
    check("r_pulse_end", 32'(req1_rvalid), 32'd0);
    check("r_rdata_hold", 32'(req1_rdata), 32'hBEEF);

    // Tie for four transactions: order 0,1,0,1
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 8'd4; req0_wdata = 16'hA0A0;
    req1_valid = 1'b1; req1_write = 1'b1; req1_address = 8'd5; req1_wdata = 16'h5151;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d", i), 32'({req1_ready, req0_ready}),
            (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check($sformatf("rr_addr%0d", i), 32'(memory_address), (i % 2 == 0) ? 32'd4 : 32'd5);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_row4", 32'(rf[4]), 32'hA0A0);
    check("rr_row5", 32'(rf[5]), 32'h5151);

    // req0 out-of-range write 0x0C
    req0_valid = 1'b1; req0_write = 1'b1; req0_address = 8'h0C; req0_wdata = 16'h1234;
    #1;
    check("oow_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("oow_strobes", 32'({memory_enable_n, memory_write_n, memory_read_n}), 32'd7);
    check("oow_err_early", 32'(req0_err), 32'd0);
    tick();
    check("oow_err", 32'(req0_err), 32'd1);
    tick();
    check("oow_err_end", 32'(req0_err), 32'd0);
    check("oow_row2", 32'(rf[2]), 32'hBEEF);
    check("oow_row12", 32'(rf[12]), 32'h0);

    // req1 out-of-range read 0x1A
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 8'h1A;
    #1;
    tick();
    req1_valid = 1'b0;
    check("oor_strobes", 32'({memory_enable_n, memory_write_n, memory_read_n}), 32'd7);
    tick();
    check("oor_early", 32'({req1_rvalid, req1_err}), 32'd0);
    tick();
    check("oor_rvalid_err", 32'({req1_rvalid, req1_err}), 32'd3);
    check("oor_rdata", 32'(req1_rdata), 32'd0);
    check("oor_port0", 32'({req0_rvalid, req0_err}), 32'd0);
    tick();
    check("oor_end", 32'({req1_rvalid, req1_err}), 32'd0);

    // Reset during CMD of a read
    req0_valid = 1'b1; req0_write = 1'b0; req0_address = 8'd2;
    #1;
    check("ra_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("ra_rd_n", 32'(memory_read_n), 32'd0);
    reset_sn = 1'b0;
    tick();
    check("ra_strobes", 32'({memory_enable_n, memory_write_n, memory_read_n}), 32'd7);
    check("ra_rvalid", 32'(req0_rvalid), 32'd0);
    reset_sn = 1'b1;
    tick();
    check("ra_no_rvalid", 32'(req0_rvalid), 32'd0);
    req0_valid = 1'b1; req0_address = 8'd5;
    #1;
    check("ra_idle_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("ra_next_rvalid", 32'(req0_rvalid), 32'd1);
    check("ra_next_rdata", 32'(req0_rdata), 32'h5151);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
